// File: rtl/qspi_bus_sched.sv
// Quad-SPI bus scheduler: arbitrates the fetch and data ports onto a shared flash/PSRAM
// bus and sequences the command, address, dummy and data phases at SCLK = clk/2.
module qspi_bus_sched #(
    parameter int FLASH_DUMMY   = 6,
    parameter int PSRAM_DUMMY   = 6,
    parameter int PSRAM_SEL_BIT = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [1:0]  d_size,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        flash_cs_n,
    output logic        ram_cs_n,
    output logic        spi_sclk,
    input  logic [3:0]  spi_io_in,
    output logic [3:0]  spi_io_out,
    output logic [3:0]  spi_io_oe
);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_DONE
    } state_t;

    localparam logic [7:0] FLASH_DUMMY_LAST = (FLASH_DUMMY > 0) ? 8'(FLASH_DUMMY - 1) : 8'd0;
    localparam logic [7:0] PSRAM_DUMMY_LAST = (PSRAM_DUMMY > 0) ? 8'(PSRAM_DUMMY - 1) : 8'd0;
    localparam logic [7:0] CMD_READ  = 8'hEB;
    localparam logic [7:0] CMD_WRITE = 8'h38;

    state_t      r_state, w_state_next;
    logic        r_sclk;
    logic [7:0]  r_cnt;
    logic        r_port;
    logic        r_last_d;
    logic        r_we;
    logic        r_psram;
    logic [1:0]  r_size;
    logic [23:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_acc;
    logic [31:0] r_i_rdata;
    logic [31:0] r_d_rdata;

    logic        w_idle, w_grant_d, w_grant_i, w_grant;
    logic        w_g_psram, w_g_we, w_active, w_no_dummy, w_phase_end;
    logic [7:0]  w_phase_last, w_cmd;
    logic [4:0]  w_nib_lsb;
    logic [3:0]  w_addr_nib;
    logic        w_unused_addr_bits;

    assign w_idle    = (r_state == S_IDLE);
    // Data wins alone; under contention the port not served last wins.
    assign w_grant_d = w_idle && d_req && (!i_req || !r_last_d);
    assign w_grant_i = w_idle && i_req && !w_grant_d;
    assign w_grant   = w_grant_d || w_grant_i;
    assign w_g_psram = w_grant_d ? d_addr[PSRAM_SEL_BIT] : i_addr[PSRAM_SEL_BIT];
    assign w_g_we    = w_grant_d && d_we;

    assign w_active    = (r_state == S_CMD) || (r_state == S_ADDR) ||
                         (r_state == S_DUMMY) || (r_state == S_DATA);
    assign w_no_dummy  = r_we || (r_psram ? (PSRAM_DUMMY == 0) : (FLASH_DUMMY == 0));
    assign w_cmd       = r_we ? CMD_WRITE : CMD_READ;
    // Ascending byte order, high nibble of each byte first.
    assign w_nib_lsb   = {r_cnt[2:1], ~r_cnt[0], 2'b00};
    assign w_phase_end = r_sclk && (r_cnt == w_phase_last);
    assign w_unused_addr_bits = ^{i_addr[31:24], d_addr[31:24]};

    always_comb begin
        w_addr_nib = 4'd0;
        case (r_cnt[2:0])
            3'd0:    w_addr_nib = r_addr[23:20];
            3'd1:    w_addr_nib = r_addr[19:16];
            3'd2:    w_addr_nib = r_addr[15:12];
            3'd3:    w_addr_nib = r_addr[11:8];
            3'd4:    w_addr_nib = r_addr[7:4];
            3'd5:    w_addr_nib = r_addr[3:0];
            default: w_addr_nib = 4'd0;
        endcase
    end

    always_comb begin
        w_phase_last = 8'd0;
        case (r_state)
            S_CMD:   w_phase_last = 8'd7;
            S_ADDR:  w_phase_last = 8'd5;
            S_DUMMY: w_phase_last = r_psram ? PSRAM_DUMMY_LAST : FLASH_DUMMY_LAST;
            S_DATA: begin
                case (r_size)
                    2'd0:    w_phase_last = 8'd1;
                    2'd1:    w_phase_last = 8'd3;
                    default: w_phase_last = 8'd7;
                endcase
            end
            default: w_phase_last = 8'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    w_state_next = (w_g_we && !w_g_psram) ? S_DONE : S_CMD;
                end
            end
            S_CMD:   if (w_phase_end) w_state_next = S_ADDR;
            S_ADDR:  if (w_phase_end) w_state_next = w_no_dummy ? S_DATA : S_DUMMY;
            S_DUMMY: if (w_phase_end) w_state_next = S_DATA;
            S_DATA:  if (w_phase_end) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Counters advance on the sclk 1->0 edge so outputs only move while sclk is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk    <= 1'b0;
            r_cnt     <= 8'd0;
            r_port    <= 1'b0;
            r_last_d  <= 1'b0;
            r_we      <= 1'b0;
            r_psram   <= 1'b0;
            r_size    <= 2'd0;
            r_addr    <= 24'd0;
            r_wdata   <= 32'd0;
            r_acc     <= 32'd0;
            r_i_rdata <= 32'd0;
            r_d_rdata <= 32'd0;
        end else if (w_grant) begin
            r_sclk   <= 1'b0;
            r_cnt    <= 8'd0;
            r_port   <= w_grant_d;
            r_last_d <= w_grant_d;
            r_we     <= w_g_we;
            r_psram  <= w_g_psram;
            r_size   <= w_grant_d ? d_size : 2'd2;
            r_addr   <= w_grant_d ? d_addr[23:0] : i_addr[23:0];
            r_wdata  <= d_wdata;
            r_acc    <= 32'd0;
        end else if (w_active) begin
            r_sclk <= ~r_sclk;
            if (r_sclk) begin
                r_cnt <= w_phase_end ? 8'd0 : r_cnt + 8'd1;
            end
            if (!r_sclk && (r_state == S_DATA) && !r_we) begin
                r_acc[w_nib_lsb +: 4] <= spi_io_in;
            end
            if (w_phase_end && (r_state == S_DATA) && !r_we) begin
                if (r_port) begin
                    r_d_rdata <= r_acc;
                end else begin
                    r_i_rdata <= r_acc;
                end
            end
        end else begin
            r_sclk <= 1'b0;
        end
    end

    always_comb begin
        flash_cs_n = 1'b1;
        ram_cs_n   = 1'b1;
        spi_sclk   = 1'b0;
        spi_io_out = 4'd0;
        spi_io_oe  = 4'd0;
        i_ready    = 1'b0;
        d_ready    = 1'b0;
        if (w_active) begin
            flash_cs_n = r_psram;
            ram_cs_n   = !r_psram;
            spi_sclk   = r_sclk;
        end
        case (r_state)
            S_CMD: begin
                spi_io_oe  = 4'b0001;
                spi_io_out = {3'b000, w_cmd[3'd7 - r_cnt[2:0]]};
            end
            S_ADDR: begin
                spi_io_oe  = 4'b1111;
                spi_io_out = w_addr_nib;
            end
            S_DATA: begin
                if (r_we) begin
                    spi_io_oe  = 4'b1111;
                    spi_io_out = r_wdata[w_nib_lsb +: 4];
                end
            end
            S_DONE: begin
                i_ready = !r_port;
                d_ready = r_port;
            end
            default: ;
        endcase
    end

    assign i_rdata = r_i_rdata;
    assign d_rdata = r_d_rdata;

endmodule

// File: tb/tb_qspi_bus_sched.sv
// Bench for qspi_bus_sched: bus-level flash/PSRAM device model, directed vector table,
// arbitration and reset sequences, and random traffic against a byte-array reference.
module tb_qspi_bus_sched;
    localparam int FD = 6;
    localparam int PD = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_ready;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [1:0]  d_size = '0;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        flash_cs_n, ram_cs_n, spi_sclk;
    logic [3:0]  spi_io_in = '0;
    logic [3:0]  spi_io_out, spi_io_oe;

    qspi_bus_sched #(.FLASH_DUMMY(FD), .PSRAM_DUMMY(PD), .PSRAM_SEL_BIT(24)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .flash_cs_n(flash_cs_n), .ram_cs_n(ram_cs_n), .spi_sclk(spi_sclk),
        .spi_io_in(spi_io_in), .spi_io_out(spi_io_out), .spi_io_oe(spi_io_oe)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Bus devices (written by DUT traffic) and reference memories (written by the model).
    logic [7:0] s_flash  [0:4095];
    logic [7:0] s_psram  [0:4095];
    logic [7:0] ref_flash[0:4095];
    logic [7:0] ref_psram[0:4095];

    int          k = 0, oe_err = 0, both_err = 0, act_cnt = 0, seen = 0, last_n = 0;
    logic [7:0]  cap_cmd = '0, last_cmd = '0;
    logic [23:0] cap_addr = '0, last_addr = '0;
    logic        cap_sel = 1'b0, last_sel = 1'b0;

    task automatic slave_step();
        int dstart, j;
        logic [11:0] idx;
        logic [7:0]  b;
        logic        wr;
        if (!flash_cs_n && !ram_cs_n) both_err++;
        cap_sel   = !ram_cs_n;
        spi_io_in = 4'($urandom);
        if (k < 8) begin
            cap_cmd = {cap_cmd[6:0], spi_io_out[0]};
            if (spi_io_oe !== 4'b0001 || spi_io_out[3:1] !== 3'b000) oe_err++;
        end else if (k < 14) begin
            cap_addr = {cap_addr[19:0], spi_io_out};
            if (spi_io_oe !== 4'b1111) oe_err++;
        end else begin
            wr     = (cap_cmd == 8'h38);
            dstart = wr ? 14 : 14 + (cap_sel ? PD : FD);
            if (k < dstart) begin
                if (spi_io_oe !== 4'b0000) oe_err++;
            end else begin
                j   = k - dstart;
                idx = 12'(cap_addr + 24'(j / 2));
                if (wr) begin
                    if (spi_io_oe !== 4'b1111) oe_err++;
                    if (cap_sel) begin
                        if (j % 2 == 0) s_psram[idx][7:4] = spi_io_out;
                        else            s_psram[idx][3:0] = spi_io_out;
                    end
                end else begin
                    if (spi_io_oe !== 4'b0000) oe_err++;
                    b = cap_sel ? s_psram[idx] : s_flash[idx];
                    spi_io_in = (j % 2 == 0) ? b[7:4] : b[3:0];
                end
            end
        end
        k++;
    endtask

    initial begin : slave
        forever begin
            @(negedge clk);
            if (spi_sclk || !flash_cs_n || !ram_cs_n) act_cnt++;
            if (flash_cs_n && ram_cs_n) begin
                if (k > 0) begin
                    seen++;
                    last_n    = k;
                    last_cmd  = cap_cmd;
                    last_addr = cap_addr;
                    last_sel  = cap_sel;
                end
                k = 0;
                spi_io_in = 4'($urandom);
            end else if (!spi_sclk) begin
                slave_step();
            end
        end
    end

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic int model_lat(input bit we, input bit psram, input logic [1:0] size);
        if (we && !psram) return 1;
        return 2 * (8 + 6 + (we ? 0 : (psram ? PD : FD)) + 2 * nbytes(size)) + 1;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr, input logic [1:0] size);
        logic [31:0] v;
        logic [11:0] a;
        v = '0;
        for (int i = 0; i < nbytes(size); i++) begin
            a = 12'(addr + 32'(i));
            v = v | (32'(addr[24] ? ref_psram[a] : ref_flash[a]) << (8 * i));
        end
        return v;
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wd);
        for (int i = 0; i < nbytes(size); i++) ref_psram[12'(addr + 32'(i))] = wd[8 * i +: 8];
    endtask

    logic [31:0] exp_i_hold = '0, exp_d_hold = '0;
    bit          d_hold_valid = 1'b1;

    task automatic do_txn(input string tag, input bit port, input bit we, input logic [31:0] addr,
                          input logic [1:0] size, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input int exp_lat);
        int lat, cs_first, stray, seen0, act0, err0;
        logic [31:0] got;
        bit bus;
        bus = !(we && !addr[24]);
        @(posedge clk); #1;
        seen0 = seen; act0 = act_cnt; err0 = oe_err + both_err;
        lat = -1; cs_first = -1; stray = 0; got = '0;
        if (port) begin
            d_we = we; d_addr = addr; d_size = size; d_wdata = wdata; d_req = 1'b1;
        end else begin
            i_addr = addr; i_req = 1'b1;
        end
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (cs_first < 0 && (!flash_cs_n || !ram_cs_n)) cs_first = c;
            if (port ? i_ready : d_ready) stray++;
            if (port ? d_ready : i_ready) begin
                lat = c;
                got = port ? d_rdata : i_rdata;
                break;
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        @(posedge clk); #1;
        $display("txn %s port=%0d we=%0d addr=%h size=%0d lat=%0d rdata=%h", tag, port, we, addr, size, lat, got);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_stray_ready"}, 32'(stray), 32'd0);
        if (!we) begin
            chk({tag, "_rdata"}, got, exp_rdata);
            if (port) begin exp_d_hold = exp_rdata; d_hold_valid = 1'b1; end
            else exp_i_hold = exp_rdata;
        end else begin
            d_hold_valid = 1'b0;
        end
        if (port) chk({tag, "_i_hold"}, i_rdata, exp_i_hold);
        else if (d_hold_valid) chk({tag, "_d_hold"}, d_rdata, exp_d_hold);
        if (bus) begin
            chk({tag, "_cs_first"}, 32'(cs_first), 32'd1);
            chk({tag, "_bursts"}, 32'(seen - seen0), 32'd1);
            chk({tag, "_nsclk"}, 32'(last_n), 32'((exp_lat - 1) / 2));
            chk({tag, "_cmd"}, 32'(last_cmd), we ? 32'h38 : 32'hEB);
            chk({tag, "_addr"}, 32'(last_addr), 32'(addr[23:0]));
            chk({tag, "_target"}, 32'(last_sel), 32'(addr[24]));
            chk({tag, "_oe"}, 32'(oe_err + both_err - err0), 32'd0);
        end else begin
            chk({tag, "_no_activity"}, 32'(act_cnt - act0), 32'd0);
            chk({tag, "_bursts"}, 32'(seen - seen0), 32'd0);
        end
    endtask

    typedef struct {
        bit          port;
        bit          we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t vecs[8];

    initial begin : main
        int          nr, nf, mism, reached;
        int          rport[3], rcyc[3], falls[4];
        logic [31:0] rdat[3];
        bit          prev, csl, rp, rw;
        logic [31:0] ra, rwd, rexp;
        logic [1:0]  rs;

        for (int i = 0; i < 4096; i++) begin
            s_flash[i] = 8'($urandom); s_psram[i] = 8'($urandom);
            ref_flash[i] = s_flash[i]; ref_psram[i] = s_psram[i];
        end
        s_flash[16] = 8'h13; s_flash[17] = 8'h57; s_flash[18] = 8'h9B; s_flash[19] = 8'hDF;
        s_psram[2] = 8'h34; s_psram[3] = 8'h12;
        for (int i = 0; i < 4096; i++) begin
            ref_flash[i] = s_flash[i]; ref_psram[i] = s_psram[i];
        end

        #3;
        chk("rst_cs", {30'd0, flash_cs_n, ram_cs_n}, 32'd3);
        chk("rst_sclk_oe", {27'd0, spi_sclk, spi_io_oe}, 32'd0);
        chk("rst_io_out", 32'(spi_io_out), 32'd0);
        chk("rst_ready", {30'd0, i_ready, d_ready}, 32'd0);
        chk("rst_rdata", i_rdata | d_rdata, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        vecs[0] = '{0, 0, 32'h0000_0010, 2'd2, 32'h0,          32'hDF9B_5713, 57};
        vecs[1] = '{1, 1, 32'h0100_0005, 2'd0, 32'h0000_00A5, 32'h0,         33};
        vecs[2] = '{1, 0, 32'h0100_0002, 2'd1, 32'h0,          32'h0000_1234, 49};
        vecs[3] = '{1, 1, 32'h0000_0100, 2'd2, 32'hCAFE_F00D, 32'h0,          1};
        vecs[4] = '{1, 0, 32'h0100_0005, 2'd0, 32'h0,          32'h0000_00A5, 45};
        vecs[5] = '{1, 0, 32'h0000_0010, 2'd3, 32'h0,          32'hDF9B_5713, 57};
        vecs[6] = '{1, 1, 32'h0100_0008, 2'd2, 32'h1122_3344, 32'h0,         45};
        vecs[7] = '{1, 0, 32'h0100_0008, 2'd2, 32'h0,          32'h1122_3344, 57};
        for (int i = 0; i < 8; i++) begin
            do_txn($sformatf("vec%0d", i), vecs[i].port, vecs[i].we, vecs[i].addr,
                   vecs[i].size, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_lat);
            if (vecs[i].we && vecs[i].addr[24]) model_write(vecs[i].addr, vecs[i].size, vecs[i].wdata);
        end
        chk("psram5_written", 32'(s_psram[5]), 32'hA5);
        chk("psram6_untouched", 32'(s_psram[6]), 32'(ref_psram[6]));

        // Reset asserted in the middle of the address phase of a fetch.
        @(posedge clk); #1;
        i_addr = 32'h10; i_req = 1'b1;
        reached = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (k >= 10) begin reached = 1; break; end
        end
        chk("midrst_reach_addr", 32'(reached), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_cs", {30'd0, flash_cs_n, ram_cs_n}, 32'd3);
        chk("midrst_sclk_oe", {27'd0, spi_sclk, spi_io_oe}, 32'd0);
        chk("midrst_ready", {30'd0, i_ready, d_ready}, 32'd0);
        chk("midrst_rdata", i_rdata | d_rdata, 32'd0);
        i_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_i_hold = '0; exp_d_hold = '0; d_hold_valid = 1'b1;
        do_txn("after_rst", 0, 0, 32'h10, 2'd2, 32'h0, 32'hDF9B_5713, 57);

        // Both ports held together for three transactions.
        @(posedge clk); #1;
        i_addr = 32'h10; d_we = 1'b0; d_addr = 32'h0100_0008; d_size = 2'd2;
        i_req = 1'b1; d_req = 1'b1;
        nr = 0; nf = 0; prev = 1'b0;
        for (int i = 0; i < 4; i++) falls[i] = 0;
        for (int i = 0; i < 3; i++) begin rport[i] = -1; rcyc[i] = 0; rdat[i] = '0; end
        for (int c = 0; c < 800 && nr < 3; c++) begin
            @(negedge clk);
            csl = !flash_cs_n || !ram_cs_n;
            if (csl && !prev && nf < 4) begin falls[nf] = c; nf++; end
            prev = csl;
            if (i_ready || d_ready) begin
                rport[nr] = d_ready ? 1 : 0; rcyc[nr] = c;
                rdat[nr] = d_ready ? d_rdata : i_rdata; nr++;
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        @(posedge clk); #1;
        $display("txn contention readies=%0d order=%0d,%0d,%0d cycles=%0d,%0d,%0d",
                 nr, rport[0], rport[1], rport[2], rcyc[0], rcyc[1], rcyc[2]);
        chk("cont_count", 32'(nr), 32'd3);
        chk("cont_first_cycle", 32'(rcyc[0]), 32'd57);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("cont%0d_port", i), 32'(rport[i]), (i == 1) ? 32'd0 : 32'd1);
            chk($sformatf("cont%0d_rdata", i), rdat[i], (i == 1) ? 32'hDF9B_5713 : model_read(32'h0100_0008, 2'd2));
        end
        for (int i = 0; i < 2; i++)
            chk($sformatf("cont%0d_cs_gap", i), 32'(falls[i + 1] - rcyc[i] >= 2), 32'd1);
        exp_i_hold = 32'hDF9B_5713; exp_d_hold = model_read(32'h0100_0008, 2'd2); d_hold_valid = 1'b1;

        for (int t = 0; t < 40; t++) begin
            rp = 1'($urandom);
            ra = $urandom;
            rwd = $urandom;
            if (rp) begin rw = 1'($urandom); rs = 2'($urandom); end
            else begin rw = 1'b0; rs = 2'd2; end
            rexp = rw ? 32'h0 : model_read(ra, rs);
            do_txn($sformatf("rnd%0d", t), rp, rw, ra, rs, rwd, rexp, model_lat(rw, ra[24], rs));
            if (rw && ra[24]) model_write(ra, rs, rwd);
        end

        mism = 0;
        for (int i = 0; i < 4096; i++) if (s_psram[i] !== ref_psram[i]) mism++;
        chk("psram_image", 32'(mism), 32'd0);
        chk("bus_protocol_total", 32'(oe_err + both_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/qspi_bus_sched.md
Name: qspi_bus_sched

Overview:
Schedules all traffic on the shared quad-SPI bus to the external flash and PSRAM, which share SCLK and IO[3:0] and have separate chip selects. It arbitrates between the core's instruction-fetch port and its data port. For each granted request it sequences the command, address, dummy and data phases. It returns the read data with a one-cycle ready pulse.

Parameters:
FLASH_DUMMY, 6, SCLK dummy cycles after the address for a flash quad read (0xEB)
PSRAM_DUMMY, 6, SCLK wait cycles after the address for a PSRAM quad read (0xEB)
PSRAM_SEL_BIT, 24, address bit that selects the target: 1 = PSRAM, 0 = flash

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
i_req  in  1  instruction fetch request; level, held until i_ready
i_addr  in  32  fetch address (word access)
i_ready  out  1  one-cycle pulse; i_rdata valid in that cycle
i_rdata  out  32  fetched word
d_req  in  1  data request; level, held until d_ready
d_we  in  1  1 = write, 0 = read
d_addr  in  32  data address
d_wdata  in  32  write data, right-aligned
d_size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word
d_ready  out  1  one-cycle pulse
d_rdata  out  32  read data, right-aligned, zero-extended
flash_cs_n  out  1  flash chip select
ram_cs_n  out  1  PSRAM chip select
spi_sclk  out  1  bus clock, SPI mode 0
spi_io_in  in  4  bus IO input
spi_io_out  out  4  bus IO output
spi_io_oe  out  4  per-bit output enable, 1 = drive

Behaviour:
- Reset (asynchronous, immediate, including mid-transfer): both CS high, sclk 0, io_out 0, io_oe 0, ready outputs 0, rdata 0, last-grant = instruction, state IDLE.
- States: IDLE -> CMD -> ADDR -> DUMMY (skipped for writes) -> DATA -> DONE -> IDLE.
- Arbitration happens in IDLE only. The data port wins when it alone is pending. When both are pending, the port not served last wins (round-robin). Address, we, size and wdata are latched at grant.
- Request dropped mid-transfer: the transaction still completes and ready still pulses. A request is re-sampled only in IDLE.
- Flash write: no bus activity. The DONE state pulses d_ready one cycle after grant.
- Target: addr[PSRAM_SEL_BIT] selects the target. Only the selected CS goes low. The bus address is addr[23:0].
- SCLK timing: SCLK = clk/2, idle low.
  - The cycle after grant: CS low, sclk 0, first bit driven.
  - sclk toggles every clk while in CMD through DATA.
  - Outputs change only while sclk is low. Inputs are sampled on the clk edge where sclk goes 0 -> 1.
- CMD phase: 8 SCLK, MSB first on io0, io_oe = 0001, io_out[3:1] = 0. Command is 0xEB for reads and 0x38 for PSRAM writes.
- ADDR phase: 6 SCLK, quad, MSB nibble first, io_oe = 1111.
- DUMMY phase: FLASH_DUMMY or PSRAM_DUMMY SCLK, io_oe = 0000.
- DATA phase: 2, 4 or 8 nibbles for byte, half or word. Bytes go in ascending address order, high nibble first within each byte. io_oe = 0000 for reads and 1111 for writes.
- Completion: let N be the total SCLK count. Ready pulses in cycle 2N+1 relative to grant (cycle 0).
  - CS goes high in the ready cycle. io_oe = 0 and sclk = 0 from that cycle.
  - At least one full CS-high cycle follows, so the earliest next grant is cycle 2N+2.
- Read latency: a flash word fetch is N = 28, so ready comes at cycle 57.
- rdata holds its value after the ready pulse until the next transaction on that port completes.

Test Plan:
- Flash fetch: i_addr=0x00000010; flash bytes 10..13 = 13 57 9B DF -> cmd bits 11101011 on io0, address nibbles 0,0,0,0,1,0, 6 dummy, i_ready at cycle 57, i_rdata=0xDF9B5713, ram_cs_n stays high.
- PSRAM byte write: d_we=1, d_addr=0x01000005, d_size=0, d_wdata=0xA5 -> ram_cs_n low, cmd 0x38, nibbles A then 5 with oe=1111, N=16, d_ready at cycle 33.
- PSRAM half read: d_addr=0x01000002, d_size=1, bytes 34 12 -> d_rdata=0x00001234, N=24, d_ready at cycle 49.
- Contention: i_req and d_req held high together for three transactions -> grants go data, instr, data, each grant at least one CS-high cycle after the previous ready.
- Flash write: d_we=1, d_addr=0x00000100 -> d_ready at cycle 1, both CS high throughout, sclk stays 0.
- Reset mid-transfer: rst_n low during the ADDR phase -> CS high, oe=0 and sclk=0 the same cycle; after release, a new fetch completes normally with correct data.
